exp_host_ctrl: RTL

EXP_HOST_CTRL -- requirements
Module: exp_host_ctrl

---
 rtl/exp_pkg.sv | 43 ++++
 rtl/exp_operand_bank.sv | 77 +++++++
 rtl/exp_host_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/exp_pkg.sv
// -----------------------------------------------------------------------------
// exp_pkg
// Shared definitions for the exponentiation host controller: default operand
// and exponent-length widths, command opcodes, controller state encoding and
// operand-bank slot numbering.
// -----------------------------------------------------------------------------
package exp_pkg;

    localparam int EXP_DW = 1024;   // operand / result width
    localparam int EXP_LW = 32;     // exponent-length field width

    // Command opcodes carried in cmd_data[2:0]
    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_LD_X    = 3'd1;
    localparam logic [2:0] OP_LD_M    = 3'd2;
    localparam logic [2:0] OP_LD_E    = 3'd3;
    localparam logic [2:0] OP_LD_R    = 3'd4;
    localparam logic [2:0] OP_LD_R2   = 3'd5;
    localparam logic [2:0] OP_SET_LEN = 3'd6;
    localparam logic [2:0] OP_RUN     = 3'd7;

    // Controller states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;

    // Operand-bank slots; each has its own loaded bit
    localparam int         NUM_SLOTS = 6;
    localparam logic [2:0] SLOT_X    = 3'd0;
    localparam logic [2:0] SLOT_M    = 3'd1;
    localparam logic [2:0] SLOT_E    = 3'd2;
    localparam logic [2:0] SLOT_R    = 3'd3;
    localparam logic [2:0] SLOT_R2   = 3'd4;
    localparam logic [2:0] SLOT_LEN  = 3'd5;

    // LD_X..LD_R2 are numbered one above their slot index
    function automatic logic [2:0] op_to_slot(input logic [2:0] op);
        return op - 3'd1;
    endfunction

endpackage

// File: rtl/exp_operand_bank.sv
// -----------------------------------------------------------------------------
// exp_operand_bank
// Holds the five DW-wide ladder operands (x, m, e, r, r2) plus the LW-wide
// exponent length, each with a sticky loaded bit. One write port selects the
// slot; the length slot takes its value from wr_len_i, the others from
// wr_data_i.
//
// Ports
//   clk, resetn             clock, synchronous active-low reset
//   wr_en_i                 write strobe
//   wr_slot_i               slot to write (SLOT_* from exp_pkg)
//   wr_data_i               operand write data (DW)
//   wr_len_i                exponent-length write data (LW)
//   x_o m_o e_o r_o r2_o    operand register outputs (DW)
//   lene_o                  exponent-length register output (LW)
//   loaded_o                one loaded bit per slot, indexed by SLOT_*
// -----------------------------------------------------------------------------
module exp_operand_bank
    import exp_pkg::*;
#(
    parameter int DW = EXP_DW,
    parameter int LW = EXP_LW
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 wr_en_i,
    input  logic [2:0]           wr_slot_i,
    input  logic [DW-1:0]        wr_data_i,
    input  logic [LW-1:0]        wr_len_i,
    output logic [DW-1:0]        x_o,
    output logic [DW-1:0]        m_o,
    output logic [DW-1:0]        e_o,
    output logic [DW-1:0]        r_o,
    output logic [DW-1:0]        r2_o,
    output logic [LW-1:0]        lene_o,
    output logic [NUM_SLOTS-1:0] loaded_o
);

    logic [DW-1:0]        x_q, m_q, e_q, r_q, r2_q;
    logic [LW-1:0]        len_q;
    logic [NUM_SLOTS-1:0] loaded_q;

    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples pre-edge values and updates together.
    // NOTE: these wide registers are reset because their zero value is visible
    // on the engine interface; plain data storage would normally skip reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_q      <= '0;
            m_q      <= '0;
            e_q      <= '0;
            r_q      <= '0;
            r2_q     <= '0;
            len_q    <= '0;
            loaded_q <= '0;
        end else if (wr_en_i) begin
            case (wr_slot_i)
                SLOT_X:   begin x_q   <= wr_data_i; loaded_q[SLOT_X]   <= 1'b1; end
                SLOT_M:   begin m_q   <= wr_data_i; loaded_q[SLOT_M]   <= 1'b1; end
                SLOT_E:   begin e_q   <= wr_data_i; loaded_q[SLOT_E]   <= 1'b1; end
                SLOT_R:   begin r_q   <= wr_data_i; loaded_q[SLOT_R]   <= 1'b1; end
                SLOT_R2:  begin r2_q  <= wr_data_i; loaded_q[SLOT_R2]  <= 1'b1; end
                SLOT_LEN: begin len_q <= wr_len_i;  loaded_q[SLOT_LEN] <= 1'b1; end
                default:  ;
            endcase
        end
    end

    assign x_o      = x_q;
    assign m_o      = m_q;
    assign e_o      = e_q;
    assign r_o      = r_q;
    assign r2_o     = r2_q;
    assign lene_o   = len_q;
    assign loaded_o = loaded_q;

endmodule

// File: rtl/exp_host_ctrl.sv
// -----------------------------------------------------------------------------
// exp_host_ctrl
// Host-side command controller for a modular-exponentiation ladder engine.
// Commands load operands (followed by one data beat), set the exponent length,
// or launch a run. A run pulses lad_start once, waits for lad_done, and offers
// the captured result on the dout handshake until it is taken.
//
// Ports
//   clk, resetn                  clock, synchronous active-low reset
//   cmd_valid/cmd_ready/cmd_data command word: [2:0] opcode, [31:3] immediate
//   din_valid/din_ready/din_data operand data beat (DW)
//   dout_valid/dout_ready/dout_data  result beat (DW)
//   x_o m_o e_o r_o r2_o         operands to the ladder engine (DW)
//   lene_o                       exponent bit-length minus one (LW)
//   lad_start                    one-cycle start pulse to the engine
//   lad_done, lad_result         engine completion pulse and result
//   busy                         controller not idle
//   err                          sticky error (incomplete RUN / stray lad_done)
// -----------------------------------------------------------------------------
module exp_host_ctrl
    import exp_pkg::*;
#(
    parameter int DW = EXP_DW,
    parameter int LW = EXP_LW
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [31:0]   cmd_data,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic [DW-1:0] din_data,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [DW-1:0] dout_data,
    output logic [DW-1:0] x_o,
    output logic [DW-1:0] m_o,
    output logic [DW-1:0] e_o,
    output logic [DW-1:0] r_o,
    output logic [DW-1:0] r2_o,
    output logic [LW-1:0] lene_o,
    output logic          lad_start,
    input  logic          lad_done,
    input  logic [DW-1:0] lad_result,
    output logic          busy,
    output logic          err
);

    logic [2:0]           state_q, state_d;
    logic [2:0]           slot_q, slot_d;      // operand slot awaiting its data beat
    logic [DW-1:0]        dout_q, dout_d;
    logic                 err_q, err_d;
    logic                 ran_q, ran_d;        // a run has been issued since reset

    logic                 bank_we;
    logic [2:0]           bank_slot;
    logic [LW-1:0]        bank_len;
    logic [NUM_SLOTS-1:0] loaded;

    logic [2:0]           opcode;
    assign opcode   = cmd_data[2:0];
    assign bank_len = LW'(cmd_data[31:3]);

    // The bank is only written from IDLE (SET_LEN) or LOAD, so operands and
    // length are frozen for the whole run.
    exp_operand_bank #(.DW(DW), .LW(LW)) u_bank (
        .clk       (clk),
        .resetn    (resetn),
        .wr_en_i   (bank_we),
        .wr_slot_i (bank_slot),
        .wr_data_i (din_data),
        .wr_len_i  (bank_len),
        .x_o       (x_o),
        .m_o       (m_o),
        .e_o       (e_o),
        .r_o       (r_o),
        .r2_o      (r2_o),
        .lene_o    (lene_o),
        .loaded_o  (loaded)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statements can infer a latch.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        dout_d    = dout_q;
        err_d     = err_q;
        ran_d     = ran_q;
        bank_we   = 1'b0;
        bank_slot = slot_q;

        case (state_q)
            ST_IDLE: begin
                // cmd_ready is high throughout IDLE, so cmd_valid means accepted
                if (cmd_valid) begin
                    case (opcode)
                        OP_NOP: ;
                        OP_LD_X, OP_LD_M, OP_LD_E, OP_LD_R, OP_LD_R2: begin
                            slot_d  = op_to_slot(opcode);
                            state_d = ST_LOAD;
                        end
                        OP_SET_LEN: begin
                            bank_we   = 1'b1;
                            bank_slot = SLOT_LEN;
                        end
                        OP_RUN: begin
                            if (&loaded) begin
                                state_d = ST_START;
                                ran_d   = 1'b1;
                            end else begin
                                err_d   = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: begin
                if (din_valid) begin
                    bank_we = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (lad_done) begin
                    dout_d  = lad_result;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (dout_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A completion with no run outstanding is a protocol error, but only
        // once a run has been issued; a done left over from before reset is
        // silently dropped.
        if (lad_done && (state_q != ST_WAIT) && ran_q) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
            ran_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            ran_q   <= ran_d;
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign din_ready  = (state_q == ST_LOAD);
    assign lad_start  = (state_q == ST_START);
    assign dout_valid = (state_q == ST_OUT);
    assign busy       = (state_q != ST_IDLE);
    assign dout_data  = dout_q;
    assign err        = err_q;

endmodule
